// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the requesters and the register-file write arbiter.
// Bypass ports exist only when REGFILE_WB_BYPASS_EN is defined.
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  logic                     stall;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0][AW-1:0]  req_addr;
  logic [NREQ-1:0][DW-1:0]  req_data;
  logic [NREQ-1:0]          req_ready;
  logic                     we3;
  logic [AW-1:0]            wa3;
  logic [DW-1:0]            wd3;
  logic                     busy;
`ifdef REGFILE_WB_BYPASS_EN
  logic [AW-1:0]            ra1;
  logic [AW-1:0]            ra2;
  logic                     fwd1_hit;
  logic                     fwd2_hit;
  logic [DW-1:0]            fwd1_data;
  logic [DW-1:0]            fwd2_data;

  modport slave (
    input  stall, req_valid, req_addr, req_data, ra1, ra2,
    output req_ready, we3, wa3, wd3, busy, fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
  );
  modport master (
    output stall, req_valid, req_addr, req_data, ra1, ra2,
    input  req_ready, we3, wa3, wd3, busy, fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
  );
`else
  modport slave (
    input  stall, req_valid, req_addr, req_data,
    output req_ready, we3, wa3, wd3, busy
  );
  modport master (
    output stall, req_valid, req_addr, req_data,
    input  req_ready, we3, wa3, wd3, busy
  );
`endif
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback units.
// Optional write-to-read forwarding enabled by REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   rr_ptr_r;
  logic [PW-1:0]   win_idx_s;
  logic [PW-1:0]   next_ptr_s;
  logic [PW-1:0]   idx_s;
  logic [NREQ-1:0] grant_s;
  logic            found_s;
  logic            xfer_s;
  logic            we3_r;
  logic [AW-1:0]   wa3_r;
  logic [DW-1:0]   wd3_r;

  // Search from rr_ptr for the first valid requester; reset and stall suppress any grant.
  always_comb begin
    grant_s   = '0;
    found_s   = 1'b0;
    win_idx_s = '0;
    idx_s     = '0;
    if (!reset && !bus.stall && (|bus.req_valid)) begin
      for (int k = 0; k < NREQ; k++) begin
        idx_s = PW'((int'(rr_ptr_r) + k) % NREQ);
        if (!found_s && bus.req_valid[idx_s]) begin
          found_s          = 1'b1;
          grant_s[idx_s]   = 1'b1;
          win_idx_s        = idx_s;
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      grant_s = '0;
    end
  end

  assign xfer_s     = |grant_s;
  assign next_ptr_s = (win_idx_s == PW'(NREQ - 1)) ? '0 : win_idx_s + PW'(1);

  // Pointer advance and registered write port; writes to $0 complete but never assert we3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_r <= '0;
      we3_r    <= 1'b0;
      wa3_r    <= '0;
      wd3_r    <= '0;
    end else if (xfer_s) begin
      rr_ptr_r <= next_ptr_s;
      we3_r    <= (bus.req_addr[win_idx_s] != '0);
      wa3_r    <= bus.req_addr[win_idx_s];
      wd3_r    <= bus.req_data[win_idx_s];
    end else begin
      we3_r    <= 1'b0;
    end
  end

  assign bus.req_ready = grant_s;
  assign bus.we3       = we3_r;
  assign bus.wa3       = wa3_r;
  assign bus.wd3       = wd3_r;
  assign bus.busy      = we3_r;

`ifdef REGFILE_WB_BYPASS_EN
  // Same-cycle read of the register being written returns the in-flight data.
  assign bus.fwd1_hit  = we3_r & (wa3_r == bus.ra1) & (bus.ra1 != '0);
  assign bus.fwd2_hit  = we3_r & (wa3_r == bus.ra2) & (bus.ra2 != '0);
  assign bus.fwd1_data = wd3_r;
  assign bus.fwd2_data = wd3_r;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (NREQ=3, AW=5, DW=32).
module tb_regfile_wb_arbiter;
  logic clk;
  logic reset;
  int   passed;
  int   total;

  regfile_wb_arbiter_if #(.NREQ(3), .AW(5), .DW(32)) bus ();

  regfile_wb_arbiter #(.NREQ(3), .AW(5), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req_valid = 3'b000;
    bus.stall     = 1'b0;
    reset         = 1'b1;
    tick();
    reset         = 1'b0;
  endtask

  initial begin
    passed        = 0;
    total         = 0;
    reset         = 1'b1;
    bus.stall     = 1'b0;
    bus.req_valid = 3'b000;
    bus.req_addr  = '0;
    bus.req_data  = '0;
`ifdef REGFILE_WB_BYPASS_EN
    bus.ra1       = 5'd0;
    bus.ra2       = 5'd0;
`endif
    tick();
    tick();

    // Reset state, and req_ready forced low while reset is high
    bus.req_valid = 3'b111;
    #1;
    check("rst_we3",   32'(bus.we3), 32'd0);
    check("rst_wa3",   32'(bus.wa3), 32'd0);
    check("rst_wd3",   bus.wd3, 32'd0);
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);

    // Reset mid-transfer: grant requester 1, reset right after capture
    reset           = 1'b0;
    bus.req_valid   = 3'b010;
    bus.req_addr[1] = 5'd7;
    bus.req_data[1] = 32'hDEADBEEF;
    #1;
    check("mid_grant1", 32'(bus.req_ready), 32'h2);
    tick();
    reset = 1'b1;
    #1;
    check("mid_we3",   32'(bus.we3), 32'd0);
    check("mid_busy",  32'(bus.busy), 32'd0);
    check("mid_ready", 32'(bus.req_ready), 32'd0);
    tick();
    reset           = 1'b0;
    bus.req_valid   = 3'b101;
    bus.req_addr[0] = 5'd3;
    bus.req_data[0] = 32'h00000011;
    bus.req_addr[2] = 5'd4;
    bus.req_data[2] = 32'h00000022;
    #1;
    check("post_rst_grant0", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 3'b000;
    #1;
    check("post_rst_we3", 32'(bus.we3), 32'd1);
    check("post_rst_wa3", 32'(bus.wa3), 32'd3);
    check("post_rst_wd3", bus.wd3, 32'h00000011);

    // Single requester 2
    do_reset();
    bus.req_valid   = 3'b100;
    bus.req_addr[2] = 5'd5;
    bus.req_data[2] = 32'h12345678;
    #1;
    check("single_ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = 3'b000;
    #1;
    check("single_we3",  32'(bus.we3), 32'd1);
    check("single_wa3",  32'(bus.wa3), 32'd5);
    check("single_wd3",  bus.wd3, 32'h12345678);
    check("single_busy", 32'(bus.busy), 32'd1);
    tick();
    check("single_we3_off", 32'(bus.we3), 32'd0);
    check("single_wa3_hold", 32'(bus.wa3), 32'd5);

    // All three continuously valid: grants 0,1,2,0,1,2 with no bubble
    do_reset();
    bus.req_addr  = {5'd12, 5'd11, 5'd10};
    bus.req_data  = {32'h00001002, 32'h00001001, 32'h00001000};
    bus.req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("rr_ready", 32'(bus.req_ready), 32'd1 << (c % 3));
      tick();
      check("rr_we3", 32'(bus.we3), 32'd1);
      check("rr_wa3", 32'(bus.wa3), 32'd10 + 32'(c % 3));
      check("rr_wd3", bus.wd3, 32'h00001000 + 32'(c % 3));
    end
    bus.req_valid = 3'b000;

    // Write to $0 is accepted, discarded, and still advances the pointer
    do_reset();
    bus.req_addr[0] = 5'd0;
    bus.req_data[0] = 32'hFFFFFFFF;
    bus.req_addr[1] = 5'd8;
    bus.req_data[1] = 32'h00000088;
    bus.req_valid   = 3'b011;
    #1;
    check("a0_ready0", 32'(bus.req_ready), 32'h1);
    tick();
    check("a0_we3",    32'(bus.we3), 32'd0);
    check("a0_busy",   32'(bus.busy), 32'd0);
    check("a0_ready1", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 3'b000;
    #1;
    check("a0_next_we3", 32'(bus.we3), 32'd1);
    check("a0_next_wa3", 32'(bus.wa3), 32'd8);
    check("a0_next_wd3", bus.wd3, 32'h00000088);

    // Stall for 3 cycles; an already registered write still lands
    do_reset();
    bus.req_addr[2] = 5'd6;
    bus.req_data[2] = 32'h00000066;
    bus.req_valid   = 3'b100;
    #1;
    check("st_pre_ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.stall       = 1'b1;
    bus.req_addr[0] = 5'd1;
    bus.req_data[0] = 32'h0000000A;
    bus.req_addr[1] = 5'd2;
    bus.req_data[1] = 32'h0000000B;
    bus.req_valid   = 3'b011;
    #1;
    check("st_we3_inflight", 32'(bus.we3), 32'd1);
    check("st_wa3_inflight", 32'(bus.wa3), 32'd6);
    check("st_ready_c0", 32'(bus.req_ready), 32'd0);
    tick();
    check("st_ready_c1", 32'(bus.req_ready), 32'd0);
    check("st_we3_c1",   32'(bus.we3), 32'd0);
    tick();
    check("st_ready_c2", 32'(bus.req_ready), 32'd0);
    bus.stall = 1'b0;
    #1;
    check("st_grant0", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 3'b010;
    #1;
    check("st_grant1", 32'(bus.req_ready), 32'h2);
    check("st_wa3_0",  32'(bus.wa3), 32'd1);
    check("st_wd3_0",  bus.wd3, 32'h0000000A);
    tick();
    bus.req_valid = 3'b000;
    check("st_we3_1", 32'(bus.we3), 32'd1);
    check("st_wa3_1", 32'(bus.wa3), 32'd2);
    check("st_wd3_1", bus.wd3, 32'h0000000B);

`ifdef REGFILE_WB_BYPASS_EN
    // Forwarding during the we3 cycle
    do_reset();
    bus.req_addr[1] = 5'd9;
    bus.req_data[1] = 32'hA5A5A5A5;
    bus.req_valid   = 3'b010;
    tick();
    bus.req_valid = 3'b000;
    bus.ra1       = 5'd9;
    bus.ra2       = 5'd0;
    #1;
    check("fwd1_hit",  32'(bus.fwd1_hit), 32'd1);
    check("fwd1_data", bus.fwd1_data, 32'hA5A5A5A5);
    check("fwd2_hit",  32'(bus.fwd2_hit), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (we3/wa3/wd3) among NREQ writeback requesters, e.g. ALU, load unit and multiply/divide unit.
- Uses round-robin arbitration with a valid/ready handshake.
- The accepted write is registered and driven to the register file one cycle later.
- Writes to $0 are accepted and discarded, because $0 is hardwired to zero in the 32-entry register file.

Parameters:
NREQ, 3, number of writeback requesters (2..8)
AW, 5, register address width (32 registers)
DW, 32, data width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  when high, no grant is issued this cycle
req_valid  input  NREQ  requester i has a write pending
req_addr  input  NREQ x AW  destination register of requester i
req_data  input  NREQ x DW  write data of requester i
req_ready  output  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
we3  output  1  register-file write enable (registered)
wa3  output  AW  register-file write address (registered)
wd3  output  DW  register-file write data (registered)
busy  output  1  a registered write is in flight (we3 high)

Behaviour:
- Reset (async, high):
  - we3=0, wa3=0, wd3=0, busy=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready is forced to all-zero while reset is high.
  - A write captured before reset is lost and never reaches the register file.
- Grant logic (combinational, same cycle):
  - If stall=1 or no req_valid is set, req_ready=0.
  - Otherwise, search indices rr_ptr, rr_ptr+1, ... modulo NREQ. The first i with req_valid[i]=1 gets req_ready[i]=1.
  - At most one bit of req_ready is set in any cycle.
  - req_ready never depends on req_valid[i] of a non-winner.
- Pointer update (on a transfer by winner g): rr_ptr <= (g+1) mod NREQ. With no transfer, rr_ptr holds.
- Fairness: with stall=0, a continuously valid requester is granted within NREQ cycles.
- Output register (latency 1): on the rising edge after a transfer:
  - wa3 <= req_addr[g], wd3 <= req_data[g].
  - we3 <= (req_addr[g] != 0).
  - busy tracks we3.
- Output register, no transfer: we3 <= 0; wa3 and wd3 hold their last values.
- Address 0: the handshake completes normally (req_ready=1), but we3 stays 0 in the next cycle. The pointer still advances.
- Same destination from two requesters in the same cycle: only the RR winner transfers. The other waits, and its write lands in a later cycle (last writer wins in grant order).
- Back-to-back: one transfer is accepted per cycle with no bubble. Sustained throughput is 1 write/cycle.
- Stall: takes effect in the same cycle it is asserted. A write already registered still appears on we3 during the stall cycle.
- Requester rule: a requester must hold req_valid, req_addr and req_data stable until it is granted. The arbiter does not check this.
- req_valid deasserted before grant: the request is dropped with no side effects.

Optional Feature:
Macro: REGFILE_WB_BYPASS_EN
- Defined:
  - Adds inputs ra1 and ra2 (AW each).
  - Adds outputs fwd1_hit, fwd2_hit (1 each) and fwd1_data, fwd2_data (DW each).
  - fwdN_hit = we3 & (wa3==raN) & (raN!=0); fwdN_data = wd3.
  - The logic is combinational, so a read of a register in the same cycle it is written returns the new value.
- Undefined:
  - These ports do not exist.
  - Read-after-write in the write cycle is resolved by the register file write/read timing alone.

Test Plan:
- Reset mid-transfer: grant requester 1 (addr 7, data 0xDEADBEEF), then pulse reset before the next edge -> we3=0, busy=0, req_ready=0 during reset; after release, the first grant goes to requester 0.
- Single requester: requester 2 writes addr 5, data 0x12345678 -> req_ready[2] in cycle 0; cycle 1 shows we3=1, wa3=5, wd3=0x12345678; cycle 2 shows we3=0.
- All three valid continuously for 6 cycles from reset -> grant order 0,1,2,0,1,2; we3=1 for 6 consecutive cycles with matching addresses and data.
- Requester 0 writes addr 0, data 0xFFFFFFFF -> req_ready[0]=1; next cycle we3=0; rr_ptr advances so requester 1 wins next.
- Stall: stall=1 for 3 cycles with requesters 0 and 1 valid -> req_ready=0 for 3 cycles, then grants 0 then 1; a write registered before the stall still appears on we3.
- With REGFILE_WB_BYPASS_EN: requester 1 writes addr 9, data 0xA5A5A5A5; in the we3 cycle drive ra1=9, ra2=0 -> fwd1_hit=1, fwd1_data=0xA5A5A5A5, fwd2_hit=0.
